// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: generates fetch requests toward the MMU and buffers
// {pc, inst, adel} entries in a circular queue for the dual-issue decoder.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_en,
    output logic [31:0] inst_addr,
    input  logic        inst_ok,
    input  logic        inst_ok_1,
    input  logic        inst_ok_2,
    input  logic [31:0] inst_data_1,
    input  logic [31:0] inst_data_2,
    input  logic [1:0]  deq_num,
    output logic        out_valid_1,
    output logic        out_valid_2,
    output logic [31:0] out_pc_1,
    output logic [31:0] out_pc_2,
    output logic [31:0] out_inst_1,
    output logic [31:0] out_inst_2,
    output logic        out_adel_1,
    output logic        out_adel_2
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop, StHalt} state_e;

    state_e        r_state, w_state_next;
    logic [31:0]   r_pc, w_pc_next;
    logic [31:0]   r_req_addr, w_req_addr_next;
    logic          r_inst_en;
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;

    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];
    logic          r_mem_adel [DEPTH];

    logic [AW:0]   w_free;
    logic [1:0]    w_deq;
    logic [1:0]    w_pop;
    logic [1:0]    w_push_num;
    logic [31:0]   w_wr0_pc, w_wr0_inst;
    logic          w_wr0_adel;
    logic [AW-1:0] w_tail_p1, w_head_p1;

    assign w_free    = (AW + 1)'(DEPTH) - r_count;
    assign w_deq     = (deq_num > 2'd2) ? 2'd2 : deq_num;
    assign w_pop     = ((AW + 1)'(w_deq) > r_count) ? r_count[1:0] : w_deq;
    assign w_tail_p1 = r_tail + AW'(1);
    assign w_head_p1 = r_head + AW'(1);

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_req_addr_next = r_req_addr;
        w_push_num      = 2'd0;
        w_wr0_pc        = r_req_addr;
        w_wr0_inst      = inst_data_1;
        w_wr0_adel      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (r_pc[1:0] != 2'b00) begin
                    if (w_free >= (AW + 1)'(1)) begin
                        w_push_num   = 2'd1;
                        w_wr0_pc     = r_pc;
                        w_wr0_inst   = 32'd0;
                        w_wr0_adel   = 1'b1;
                        w_state_next = StHalt;
                    end
                end else if (w_free >= (AW + 1)'(2)) begin
                    w_state_next    = StReq;
                    w_req_addr_next = r_pc;
                end
            end
            StReq: begin
                if (inst_ok) begin
                    if (inst_ok_1) begin
                        w_push_num = inst_ok_2 ? 2'd2 : 2'd1;
                    end
                    w_pc_next    = r_req_addr + {28'd0, w_push_num, 2'b00};
                    w_state_next = StIdle;
                end
            end
            StDrop: begin
                if (inst_ok) begin
                    w_state_next = StIdle;
                end
            end
            StHalt: begin
            end
        endcase

        // A redirect overrides everything; an in-flight request without its
        // response this cycle must have that response swallowed in StDrop.
        if (redirect_valid) begin
            w_push_num      = 2'd0;
            w_pc_next       = redirect_pc;
            w_req_addr_next = r_req_addr;
            if (r_state == StReq || r_state == StDrop) begin
                w_state_next = inst_ok ? StIdle : StDrop;
            end else begin
                w_state_next = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_req_addr <= 32'd0;
            r_inst_en  <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_req_addr <= w_req_addr_next;
            r_inst_en  <= (w_state_next == StReq) || (w_state_next == StDrop);
            if (redirect_valid) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                r_head  <= r_head + AW'(w_pop);
                r_tail  <= r_tail + AW'(w_push_num);
                r_count <= r_count + (AW + 1)'(w_push_num) - (AW + 1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push_num != 2'd0) begin
                r_mem_pc[r_tail]   <= w_wr0_pc;
                r_mem_inst[r_tail] <= w_wr0_inst;
                r_mem_adel[r_tail] <= w_wr0_adel;
            end
            if (w_push_num == 2'd2) begin
                r_mem_pc[w_tail_p1]   <= r_req_addr + 32'd4;
                r_mem_inst[w_tail_p1] <= inst_data_2;
                r_mem_adel[w_tail_p1] <= 1'b0;
            end
        end
    end

    assign inst_en     = r_inst_en;
    assign inst_addr   = r_req_addr;
    assign out_valid_1 = (r_count != '0);
    assign out_valid_2 = (r_count >= (AW + 1)'(2));
    assign out_pc_1    = out_valid_1 ? r_mem_pc[r_head] : 32'd0;
    assign out_pc_2    = out_valid_2 ? r_mem_pc[w_head_p1] : 32'd0;
    assign out_inst_1  = out_valid_1 ? r_mem_inst[r_head] : 32'd0;
    assign out_inst_2  = out_valid_2 ? r_mem_inst[w_head_p1] : 32'd0;
    assign out_adel_1  = out_valid_1 & r_mem_adel[r_head];
    assign out_adel_2  = out_valid_2 & r_mem_adel[w_head_p1];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the fetch front end.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk, rst, redirect_valid, inst_en, inst_ok, inst_ok_1, inst_ok_2;
    logic [31:0] redirect_pc, inst_addr, inst_data_1, inst_data_2;
    logic [1:0]  deq_num;
    logic        out_valid_1, out_valid_2, out_adel_1, out_adel_2;
    logic [31:0] out_pc_1, out_pc_2, out_inst_1, out_inst_2;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_ok_1(inst_ok_1),
        .inst_ok_2(inst_ok_2), .inst_data_1(inst_data_1), .inst_data_2(inst_data_2),
        .deq_num(deq_num), .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .out_pc_1(out_pc_1), .out_pc_2(out_pc_2), .out_inst_1(out_inst_1),
        .out_inst_2(out_inst_2), .out_adel_1(out_adel_1), .out_adel_2(out_adel_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } ent_t;

    // Model: queue contents, next fetch pc, and whether a request is outstanding.
    ent_t        mq[$];
    logic [31:0] m_pc, m_addr;
    bit          m_busy, m_discard, m_halt, m_on;
    int          checks   = 0;
    int          failures = 0;
    int          lat_cnt  = 0;
    int          lat_tgt  = 2;
    int          seq      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int free, pops, n;
        free = DEPTH - mq.size();
        pops = (int'(deq_num) > mq.size()) ? mq.size() : int'(deq_num);
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC; m_addr = 32'd0;
            m_busy = 0; m_discard = 0; m_halt = 0; m_on = 1;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc   = redirect_pc;
            m_halt = 0;
            if (m_busy) begin
                if (inst_ok) begin m_busy = 0; m_discard = 0; end
                else m_discard = 1;
            end
        end else begin
            if (m_busy) begin
                if (inst_ok) begin
                    if (!m_discard) begin
                        n = 0;
                        if (inst_ok_1) begin
                            mq.push_back({m_addr, inst_data_1, 1'b0});
                            n = 1;
                            if (inst_ok_2) begin
                                mq.push_back({m_addr + 32'd4, inst_data_2, 1'b0});
                                n = 2;
                            end
                        end
                        m_pc = m_addr + 32'(4 * n);
                    end
                    m_busy = 0; m_discard = 0;
                end
            end else if (!m_halt) begin
                if (m_pc[1:0] != 2'b00) begin
                    if (free >= 1) begin
                        mq.push_back({m_pc, 32'd0, 1'b1});
                        m_halt = 1;
                    end
                end else if (free >= 2) begin
                    m_busy = 1;
                    m_addr = m_pc;
                end
            end
            for (int i = 0; i < pops; i++) void'(mq.pop_front());
        end
    end

    always @(negedge clk) begin : compare
        ent_t e1, e2;
        if (m_on) begin
            e1 = '0; e2 = '0;
            if (mq.size() >= 1) e1 = mq[0];
            if (mq.size() >= 2) e2 = mq[1];
            check("inst_en", inst_en, m_busy);
            check("inst_addr", inst_addr, m_addr);
            check("out_valid_1", out_valid_1, mq.size() >= 1);
            check("out_valid_2", out_valid_2, mq.size() >= 2);
            check("out_pc_1", out_pc_1, e1.pc);
            check("out_pc_2", out_pc_2, e2.pc);
            check("out_inst_1", out_inst_1, e1.inst);
            check("out_inst_2", out_inst_2, e2.inst);
            check("out_adel_1", out_adel_1, e1.adel);
            check("out_adel_2", out_adel_2, e2.adel);
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_ok();
        inst_ok = 0; inst_ok_1 = 0; inst_ok_2 = 0;
    endtask

    task automatic wait_en(input string name);
        int k = 0;
        while (!inst_en && k < 20) begin
            tick();
            k++;
        end
        check({name, "_en_seen"}, inst_en, 1'b1);
    endtask

    // MMU stand-in: answers a held request after lat_tgt+1 cycles.
    task automatic drive_mmu(input bit rnd);
        clear_ok();
        if (inst_en) begin
            if (lat_cnt >= lat_tgt) begin
                inst_ok     = 1;
                inst_ok_1   = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
                inst_ok_2   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                seq++;
                inst_data_1 = rnd ? $urandom : 32'(seq);
                seq++;
                inst_data_2 = rnd ? $urandom : 32'(seq);
                lat_cnt     = 0;
                lat_tgt     = rnd ? $urandom_range(0, 3) : 2;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
            if (rnd && $urandom_range(0, 9) == 0) begin
                inst_ok = 1; inst_ok_1 = 1; inst_ok_2 = 1;
                inst_data_1 = $urandom; inst_data_2 = $urandom;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        rst = 1; redirect_valid = 0; redirect_pc = 0; deq_num = 0;
        inst_data_1 = 0; inst_data_2 = 0;
        clear_ok();
        repeat (3) tick();
        check("reset_valid_1", out_valid_1, 1'b0);
        check("reset_en", inst_en, 1'b0);
        check("reset_addr", inst_addr, 32'd0);
        rst = 0;

        // Fill with two-word responses, no dequeue.
        repeat (40) begin drive_mmu(0); tick(); end
        clear_ok();
        check("fill_en_low", inst_en, 1'b0);
        check("fill_pc_1", out_pc_1, 32'hBFC0_0000);
        check("fill_inst_1", out_inst_1, 32'd1);
        check("fill_pc_2", out_pc_2, 32'hBFC0_0004);
        check("fill_inst_2", out_inst_2, 32'd2);
        deq_num = 2;
        drive_mmu(0); tick();
        check("pop1_pc_1", out_pc_1, 32'hBFC0_0008);
        check("pop1_inst_1", out_inst_1, 32'd3);
        drive_mmu(0); tick();
        check("pop2_pc_1", out_pc_1, 32'hBFC0_0010);
        drive_mmu(0); tick();
        check("pop3_pc_1", out_pc_1, 32'hBFC0_0018);
        check("pop3_pc_2", out_pc_2, 32'hBFC0_001C);
        check("pop3_inst_2", out_inst_2, 32'd8);
        deq_num = 0;
        clear_ok();

        // Single-word response advances pc by 4 only.
        rst = 1; tick(); rst = 0;
        wait_en("ok1");
        tick();
        inst_ok = 1; inst_ok_1 = 1; inst_ok_2 = 0; inst_data_1 = 32'hA;
        tick(); clear_ok();
        wait_en("ok1_next");
        check("ok1_next_addr", inst_addr, 32'hBFC0_0004);
        check("ok1_valid_2", out_valid_2, 1'b0);

        // Misaligned redirect target: single adel marker, then halt.
        rst = 1; tick(); rst = 0;
        redirect_valid = 1; redirect_pc = 32'h8000_0002;
        tick(); redirect_valid = 0;
        tick();
        check("adel_valid_1", out_valid_1, 1'b1);
        check("adel_flag_1", out_adel_1, 1'b1);
        check("adel_pc_1", out_pc_1, 32'h8000_0002);
        repeat (5) tick();
        check("halt_en_low", inst_en, 1'b0);
        check("halt_valid_2", out_valid_2, 1'b0);

        redirect_valid = 1; redirect_pc = 32'h8000_1000;
        tick(); redirect_valid = 0;
        wait_en("unhalt");
        check("unhalt_addr", inst_addr, 32'h8000_1000);

        // Redirect while a request is in flight; its late response is dropped.
        redirect_valid = 1; redirect_pc = 32'h8000_2000;
        tick(); redirect_valid = 0;
        tick();
        inst_ok = 1; inst_ok_1 = 1; inst_ok_2 = 1;
        inst_data_1 = 32'hDEAD; inst_data_2 = 32'hDEAD;
        tick(); clear_ok();
        wait_en("after_drop");
        check("after_drop_addr", inst_addr, 32'h8000_2000);
        check("after_drop_valid", out_valid_1, 1'b0);
        tick();
        inst_ok = 1; inst_ok_1 = 1; inst_ok_2 = 1;
        inst_data_1 = 32'h1111; inst_data_2 = 32'h2222;
        tick(); clear_ok();
        tick();
        check("new_inst_1", out_inst_1, 32'h1111);
        check("new_inst_2", out_inst_2, 32'h2222);
        check("new_pc_1", out_pc_1, 32'h8000_2000);

        // Redirect in the same cycle as the response.
        wait_en("same");
        inst_ok = 1; inst_ok_1 = 1; inst_ok_2 = 1; inst_data_1 = 32'hDEAD;
        redirect_valid = 1; redirect_pc = 32'h8000_3000;
        tick(); clear_ok(); redirect_valid = 0;
        wait_en("same_next");
        check("same_next_addr", inst_addr, 32'h8000_3000);
        check("same_valid", out_valid_1, 1'b0);

        // Over-dequeue with a single entry.
        inst_ok = 1; inst_ok_1 = 1; inst_ok_2 = 0; inst_data_1 = 32'h33;
        tick(); clear_ok();
        check("one_valid_1", out_valid_1, 1'b1);
        check("one_valid_2", out_valid_2, 1'b0);
        deq_num = 2;
        tick(); deq_num = 0;
        check("underflow_valid", out_valid_1, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            r = $urandom;
            if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
            redirect_pc = r;
            deq_num     = 2'($urandom_range(0, 2));
            drive_mmu(1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction-fetch front end directly upstream of the MMU instruction channel. It generates the fetch PC and drives inst_en/inst_addr. It accepts the one- or two-word responses (inst_ok/inst_ok_1/inst_ok_2) and buffers {pc, inst} pairs in a circular queue that feeds the dual-issue decoder. It also handles branch/exception redirects, including discarding a response that is already in flight.

Parameters:
DEPTH, 8, queue entries; power of two, at least 4
RESET_PC, 32'hBFC0_0000, fetch PC after reset

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  32  new fetch PC
inst_en  out  1  fetch request to MMU
inst_addr  out  32  fetch address, virtual
inst_ok  in  1  request complete, 1-cycle pulse
inst_ok_1  in  1  inst_data_1 valid (word at inst_addr)
inst_ok_2  in  1  inst_data_2 valid (word at inst_addr+4)
inst_data_1  in  32  first word
inst_data_2  in  32  second word
deq_num  in  2  entries decode consumes this cycle (0..2)
out_valid_1  out  1  head entry valid
out_valid_2  out  1  head+1 entry valid
out_pc_1  out  32  head PC
out_pc_2  out  32  head+1 PC
out_inst_1  out  32  head instruction
out_inst_2  out  32  head+1 instruction
out_adel_1  out  1  head entry is a misaligned-fetch marker
out_adel_2  out  1  head+1 entry is a misaligned-fetch marker

Behaviour:
- Reset: queue empty, count=0, pc=RESET_PC, state IDLE, inst_en=0, inst_addr=0, all out_valid_*=0, out_adel_*=0, pc/inst outputs 0.
- Storage: DEPTH entries of {pc[31:0], inst[31:0], adel}. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Outputs are combinational from the head and head+1 (wrapping). out_valid_1 = count>=1; out_valid_2 = count>=2.
- Pop: deq_num is clamped to count. Head advances by the clamped value at the clock edge.
- FSM states: IDLE, REQ, DROP, HALT.
  - IDLE:
    - If pc[1:0]!=0: push one entry {pc, 0, adel=1} when free>=1, then go to HALT.
    - Else if free>=2: go to REQ and latch req_addr=pc.
    - free = DEPTH-count, sampled before this cycle's pop.
  - REQ:
    - inst_en=1 and inst_addr=req_addr, held stable until inst_ok.
    - On inst_ok: push word1 (pc=req_addr) if inst_ok_1, then word2 (pc=req_addr+4) if inst_ok_2; word2 is pushed only if ok_1 was also set.
    - pc <= req_addr + 4*pushed, so a response with neither flag refetches the same PC. Return to IDLE.
  - DROP:
    - inst_en=1, inst_addr unchanged.
    - On inst_ok: nothing pushed; go to IDLE.
  - HALT: no fetch; exits only on redirect.
- inst_en is registered, equal to state in {REQ, DROP}. No new request issues in the cycle inst_ok is seen; minimum one IDLE cycle between requests.
- Redirect, which has highest priority:
  - Next cycle: count=0, head=tail, pc=redirect_pc, out_valid_*=0.
  - Any same-cycle push or pop is ignored.
  - In REQ without inst_ok that cycle: go to DROP.
  - In REQ with inst_ok that cycle: response discarded, go to IDLE.
  - In DROP with inst_ok: go to IDLE; otherwise stay in DROP.
  - In IDLE or HALT: go to IDLE.
- Simultaneous push and pop: count_next = count + pushes - pops. Because free>=2 is required at issue, pushes never exceed capacity.
- Reset mid-request: the FSM returns to IDLE. Any later inst_ok is ignored in IDLE.
- inst_ok outside REQ/DROP is ignored.

Test Plan:
- Reset, MMU answers each request 3 cycles later with ok_1=ok_2=1 and data 0x1..0x8, deq_num=0 -> queue fills with 8 entries at pc BFC00000..BFC0001C; inst_en stays low once free<2.
- Response with ok_1=1, ok_2=0 at pc 0xBFC00004 -> one entry pushed; next inst_addr=0xBFC00008.
- redirect_valid to 0x80001000 while in REQ, then inst_ok 2 cycles later with data 0xDEAD -> 0xDEAD never appears; next inst_addr=0x80001000; out_valid_1=0 until the new response.
- Redirect in the same cycle as inst_ok -> response discarded; next request at the redirect target.
- Queue holding 7 entries, deq_num=2 while a 2-word push arrives -> count becomes 7; head/tail wrap correctly; out_pc_1/out_pc_2 stay consecutive across index DEPTH-1 to 0.
- redirect_pc=0x80000002 -> no inst_en; one entry with out_adel_1=1, out_pc_1=0x80000002; HALT until the next redirect.
- deq_num=2 with count=1 -> count becomes 0, no underflow.
